// File: rtl/accum_arbiter.sv
// accum_arbiter: round-robin access to one shared WIDTH-bit accumulator.
// Requesters send add/sub/clear/read commands. One command is granted at
// a time, executed in a single cycle, and the post-operation accumulator
// value is returned on one response port that honours backpressure.

// Per-requester command gate: passes the lane's op/data only when the lane
// holds the grant, so the top can merge all lanes with a plain OR.
module accum_arbiter_lane #(
  parameter int WIDTH = 16
) (
  input  logic             sel,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [1:0]       op_m,
  output logic [WIDTH-1:0] data_m
);
  assign op_m   = sel ? op   : '0;
  assign data_m = sel ? data : '0;
endmodule

module accum_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 16,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       io_req_valid,
  output logic [NREQ-1:0]       io_req_ready,
  input  logic [2*NREQ-1:0]     io_req_op,
  input  logic [WIDTH*NREQ-1:0] io_req_data,
  output logic                  io_resp_valid,
  input  logic                  io_resp_ready,
  output logic [IDW-1:0]        io_resp_id,
  output logic [WIDTH-1:0]      io_resp_data,
  output logic [WIDTH-1:0]      io_acc,
  output logic                  io_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [IDW-1:0]   id;
  } cmd_t;

  localparam logic [1:0]   OP_ADD = 2'd0;
  localparam logic [1:0]   OP_SUB = 2'd1;
  localparam logic [1:0]   OP_CLR = 2'd2;
  // Ring size in the same width as the scan arithmetic (one extra bit so
  // ptr + offset never overflows before the wrap test).
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t                     state;
  logic [IDW-1:0]             ptr;
  cmd_t                       cmd;
  cmd_t                       cmd_in;
  logic [WIDTH-1:0]           acc;
  logic [WIDTH-1:0]           acc_nxt;

  logic [NREQ-1:0][1:0]       op_arr;
  logic [NREQ-1:0][WIDTH-1:0] data_arr;
  logic [NREQ-1:0][1:0]       op_m;
  logic [NREQ-1:0][WIDTH-1:0] data_m;

  logic                       found;
  logic [IDW-1:0]             win;
  logic [IDW-1:0]             ptr_nxt;
  logic [NREQ-1:0]            grant_oh;
  logic                       take;

  assign op_arr   = io_req_op;
  assign data_arr = io_req_data;

  // Round-robin scan: first valid requester starting at ptr, wrapping.
  always_comb begin
    logic [IDW:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && io_req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority.
  always_comb begin
    logic [IDW:0] inc;
    inc = {1'b0, win} + (IDW+1)'(1);
    if (inc == NREQ_W) inc = '0;
    ptr_nxt = inc[IDW-1:0];
  end

  // Grant is combinational from valid, only while idle and out of reset.
  assign grant_oh     = found ? (NREQ'(1) << win) : '0;
  assign io_req_ready = (state == IDLE && !reset) ? grant_oh : '0;
  assign take         = |io_req_ready;

  accum_arbiter_lane #(.WIDTH(WIDTH)) u_lane [NREQ-1:0] (
    .sel    (grant_oh),
    .op     (op_arr),
    .data   (data_arr),
    .op_m   (op_m),
    .data_m (data_m)
  );

  // Merge the gated lanes into the command captured on the handshake.
  always_comb begin
    cmd_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      cmd_in.op   = cmd_in.op   | op_m[i];
      cmd_in.data = cmd_in.data | data_m[i];
    end
    cmd_in.id = win;
  end

  // Accumulator datapath; unsigned, wraps modulo 2^WIDTH.
  always_comb begin
    acc_nxt = acc;
    case (cmd.op)
      OP_ADD:  acc_nxt = acc + cmd.data;
      OP_SUB:  acc_nxt = acc - cmd.data;
      OP_CLR:  acc_nxt = '0;
      default: acc_nxt = acc;
    endcase
  end

  // Sequencer: grant in IDLE, update acc in EXEC, hold the response in RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      cmd           <= '0;
      acc           <= '0;
      io_resp_valid <= 1'b0;
      io_resp_id    <= '0;
      io_resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            cmd   <= cmd_in;
            ptr   <= ptr_nxt;
            state <= EXEC;
          end
        end
        EXEC: begin
          acc           <= acc_nxt;
          io_resp_data  <= acc_nxt;
          io_resp_id    <= cmd.id;
          io_resp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (io_resp_ready) begin
            io_resp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_acc  = acc;
  assign io_busy = (state != IDLE);

endmodule
